// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect request, IF/ID
// handshake and status. master = fetch_unit, slave = memory/decode side.
interface fetch_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_inst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    logic              halted;
    logic              misaligned;
    logic [15:0]       fetch_count;

    modport master (
        output imem_addr, id_valid, id_inst, id_pc, halted, misaligned, fetch_count,
        input  imem_inst, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_inst, id_pc, halted, misaligned, fetch_count,
        output imem_inst, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory
// and holds one instruction in the IF/ID register behind a valid/ready handshake.
module fetch_unit #(
    parameter int                ADDR_W    = 16,
    parameter int                INST_W    = 16,
    parameter int                MEM_BYTES = 128,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master f
);
    typedef enum logic {FETCH, HALT} state_t;

    // One extra bit so MEM_BYTES == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] MEM_END = (ADDR_W+1)'(MEM_BYTES);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              id_valid;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    logic              misaligned;
    logic [15:0]       fetch_count;

    logic can_load;
    logic in_range;

    assign can_load = !id_valid || f.id_ready;
    assign in_range = {1'b0, pc} < MEM_END;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_inst     <= '0;
            id_pc       <= '0;
            misaligned  <= 1'b0;
            fetch_count <= '0;
        end else begin
            misaligned <= 1'b0;
            if (f.redirect_valid) begin
                // Flush only the valid bit; payload keeps its stale contents.
                pc         <= {f.redirect_pc[ADDR_W-1:1], 1'b0};
                id_valid   <= 1'b0;
                state      <= FETCH;
                misaligned <= f.redirect_pc[0];
            end else if (state == FETCH) begin
                if (!in_range) begin
                    state    <= HALT;
                    id_valid <= id_valid && !f.id_ready;
                end else if (can_load) begin
                    id_inst  <= f.imem_inst;
                    id_pc    <= pc;
                    id_valid <= 1'b1;
                    pc       <= pc + ADDR_W'(2);
                    if (fetch_count != 16'hFFFF)
                        fetch_count <= fetch_count + 16'd1;
                end
            end else begin
                if (f.id_ready)
                    id_valid <= 1'b0;
            end
        end
    end

    assign f.imem_addr   = pc;
    assign f.id_valid    = id_valid;
    assign f.id_inst     = id_inst;
    assign f.id_pc       = id_pc;
    assign f.halted      = (state == HALT);
    assign f.misaligned  = misaligned;
    assign f.fetch_count = fetch_count;
endmodule
